// File: rtl/mp_regfile_sb_pkg.sv
// Shared constants for the mp register file with scoreboard: half selectors
// and default geometry of the mp core family.
package mp_regfile_sb_pkg;
  localparam int RF_HALF_LO = 0;
  localparam int RF_HALF_HI = 1;
  localparam int DEF_NREG   = 16;
  localparam int DEF_NRD    = 3;
  localparam int DEF_NWR    = 2;
endpackage

// File: rtl/mp_regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports,
// reservation request and scoreboard status.
interface mp_regfile_sb_if
  import mp_regfile_sb_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR,
  parameter int AW   = $clog2(NREG) + 1
);
  logic [NRD*AW-1:0] rd_adr;
  logic [NRD-1:0]    rd_w32;
  logic [NRD*16-1:0] rd_data16;
  logic [NRD*32-1:0] rd_data32;
  logic [NRD-1:0]    rd_rdy;
  logic [NWR-1:0]    wr_en;
  logic [NWR-1:0]    wr_w32;
  logic [NWR*AW-1:0] wr_adr;
  logic [NWR*32-1:0] wr_data;
  // Reservation handshake: a destination is recorded only on a cycle where
  // rsv_en and rsv_ok are both high; otherwise nothing is recorded and decode
  // keeps rsv_en asserted with the same target and retries next cycle.
  logic              rsv_en;
  logic              rsv_w32;
  logic [AW-1:0]     rsv_adr;
  logic              rsv_ok;
  logic              flush;
  logic [2*NREG-1:0] sb_pend;
  logic              sb_busy;

  modport master (
    output rd_adr, rd_w32, wr_en, wr_w32, wr_adr, wr_data,
           rsv_en, rsv_w32, rsv_adr, flush,
    input  rd_data16, rd_data32, rd_rdy, rsv_ok, sb_pend, sb_busy
  );
  modport slave (
    input  rd_adr, rd_w32, wr_en, wr_w32, wr_adr, wr_data,
           rsv_en, rsv_w32, rsv_adr, flush,
    output rd_data16, rd_data32, rd_rdy, rsv_ok, sb_pend, sb_busy
  );
endinterface

// File: rtl/mp_regfile_sb_scoreboard.sv
// Pending-half tracker: merges reservation, write clears and flush, and
// decides whether a reservation may be accepted this cycle.
module mp_regfile_sb_scoreboard #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG) + 1
) (
  input  logic              clk,
  input  logic              ext_rst,
  input  logic              rsv_en,
  input  logic              rsv_w32,
  input  logic [AW-1:0]     rsv_adr,
  input  logic              flush,
  input  logic [2*NREG-1:0] wr_cov,
  output logic [2*NREG-1:0] sb_pend,
  output logic              rsv_ok,
  output logic              sb_busy
);
  logic [2*NREG-1:0] tgt;
  logic [2*NREG-1:0] pend_nxt;

  // Entry 0 is never tracked, so its target mask stays empty.
  always_comb begin
    tgt = '0;
    if (rsv_adr[AW-1:1] != '0) begin
      if (rsv_w32) begin
        tgt[{rsv_adr[AW-1:1], 1'b0}] = 1'b1;
        tgt[{rsv_adr[AW-1:1], 1'b1}] = 1'b1;
      end else begin
        tgt[rsv_adr] = 1'b1;
      end
    end
  end

  always_comb begin
    rsv_ok   = ((tgt & sb_pend & ~wr_cov) == '0) && !flush;
    pend_nxt = (sb_pend & ~wr_cov) | ((rsv_en && rsv_ok) ? tgt : '0);
    if (flush) pend_nxt = '0;
  end

  always_ff @(posedge clk or posedge ext_rst) begin
    if (ext_rst) sb_pend <= '0;
    else         sb_pend <= pend_nxt;
  end

  assign sb_busy = |sb_pend;
endmodule

// File: rtl/mp_regfile_sb.sv
// Multi-port half/word register file with write-through bypass and an
// integrated pending-write scoreboard; sits between decode and writeback.
module mp_regfile_sb
  import mp_regfile_sb_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR,
  localparam int AW  = $clog2(NREG) + 1,
  localparam int NH  = 2 * NREG
) (
  input logic           clk,
  input logic           ext_rst,
  mp_regfile_sb_if.slave bus
);
  logic [15:0]   mem  [NH];
  logic [15:0]   wdat [NH];
  logic [NH-1:0] wen;
  logic [NH-1:0] pend;

  // Ports are applied in ascending order so the highest index wins a half.
  always_comb begin
    wen = '0;
    for (int k = 0; k < NH; k++) wdat[k] = '0;
    for (int p = 0; p < NWR; p++) begin
      if (bus.wr_en[p]) begin
        if (bus.wr_w32[p]) begin
          wen [{bus.wr_adr[p*AW+1 +: AW-1], 1'b0}] = 1'b1;
          wdat[{bus.wr_adr[p*AW+1 +: AW-1], 1'b0}] = bus.wr_data[p*32 +: 16];
          wen [{bus.wr_adr[p*AW+1 +: AW-1], 1'b1}] = 1'b1;
          wdat[{bus.wr_adr[p*AW+1 +: AW-1], 1'b1}] = bus.wr_data[p*32+16 +: 16];
        end else begin
          wen [bus.wr_adr[p*AW +: AW]] = 1'b1;
          wdat[bus.wr_adr[p*AW +: AW]] = bus.wr_data[p*32 +: 16];
        end
      end
    end
    wen[RF_HALF_HI:RF_HALF_LO] = 2'b00;
  end

  always_ff @(posedge clk or posedge ext_rst) begin
    if (ext_rst) begin
      for (int k = 0; k < NH; k++) mem[k] <= '0;
    end else begin
      for (int k = 0; k < NH; k++) if (wen[k]) mem[k] <= wdat[k];
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra, lo_i, hi_i;
    logic [15:0]   dlo, dhi;
    logic          plo, phi;
    assign ra   = bus.rd_adr[i*AW +: AW];
    assign lo_i = {ra[AW-1:1], 1'b0};
    assign hi_i = {ra[AW-1:1], 1'b1};
    assign dlo  = wen[lo_i] ? wdat[lo_i] : mem[lo_i];
    assign dhi  = wen[hi_i] ? wdat[hi_i] : mem[hi_i];
    // A half written this cycle is already available through the bypass.
    assign plo  = pend[lo_i] && !wen[lo_i];
    assign phi  = pend[hi_i] && !wen[hi_i];
    assign bus.rd_data32[i*32 +: 32] = {dhi, dlo};
    assign bus.rd_data16[i*16 +: 16] = ra[0] ? dhi : dlo;
    assign bus.rd_rdy[i] = bus.rd_w32[i] ? !(plo || phi) : !(ra[0] ? phi : plo);
  end

  mp_regfile_sb_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk     (clk),
    .ext_rst (ext_rst),
    .rsv_en  (bus.rsv_en),
    .rsv_w32 (bus.rsv_w32),
    .rsv_adr (bus.rsv_adr),
    .flush   (bus.flush),
    .wr_cov  (wen),
    .sb_pend (pend),
    .rsv_ok  (bus.rsv_ok),
    .sb_busy (bus.sb_busy)
  );

  assign bus.sb_pend = pend;
endmodule
